// File: rtl/div_top.sv
// div_top: iterative restoring unsigned divider, one quotient bit per enabled clock
module div_top #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic             n,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a, b, r, a_nxt, r_nxt;
  logic [WIDTH:0] trial;
  logic sel, fit;
  always_comb begin
    trial = {r, a[WIDTH-1]};
    fit = trial >= {1'b0, b};
    r_nxt = fit ? WIDTH'(trial - {1'b0, b}) : trial[WIDTH-1:0];
    a_nxt = {a[WIDTH-2:0], fit};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      a <= '0;
      b <= '0;
      r <= '0;
      sel <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else if (clk_en) begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a <= dataa;
          b <= datab;
          sel <= n;
          r <= '0;
          cnt <= '0;
          state <= RUN;
        end
      end else begin
        a <= a_nxt;
        r <= r_nxt;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state <= IDLE;
          done <= 1'b1;
          result <= sel ? r_nxt : a_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_div_top.sv
// tb_div_top: directed vector and corner-sequence checks for div_top
module tb_div_top;
  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b0, start = 1'b0, n = 1'b0, done;
  logic [31:0] dataa = '0, datab = '0, result;
  int total = 0, bad = 0;
  div_top #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataa(dataa), .datab(datab), .n(n), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        n;
    logic [31:0] exp;
  } vec_t;
  vec_t v[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic go(input logic [31:0] a, input logic [31:0] b, input logic nn);
    @(negedge clk);
    dataa = a;
    datab = b;
    n = nn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 200);
  endtask
  initial begin
    int lat;
    logic ok;
    v[0]  = '{32'd7, 32'd2, 1'b0, 32'd3};
    v[1]  = '{32'd7, 32'd2, 1'b1, 32'd1};
    v[2]  = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF};
    v[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000};
    v[4]  = '{32'd5, 32'd0, 1'b0, 32'hFFFFFFFF};
    v[5]  = '{32'd5, 32'd0, 1'b1, 32'd5};
    v[6]  = '{32'd1000, 32'd3, 1'b0, 32'd333};
    v[7]  = '{32'd1000, 32'd3, 1'b1, 32'd1};
    v[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1};
    v[9]  = '{32'h12345678, 32'd1000, 1'b0, 32'd305419};
    v[10] = '{32'h12345678, 32'd1000, 1'b1, 32'd896};
    v[11] = '{32'd0, 32'd5, 1'b0, 32'd0};
    repeat (3) @(negedge clk);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    reset = 1'b0;
    clk_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      go(v[i].a, v[i].b, v[i].n);
      wait_done(lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd32);
      chk($sformatf("vec%0d result", i), result, v[i].exp);
      @(negedge clk);
      chk($sformatf("vec%0d done pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("vec%0d result hold", i), result, v[i].exp);
    end
    go(32'd332, 32'd22, 1'b0);
    wait_done(lat);
    chk("b2b first latency", 32'(lat), 32'd32);
    chk("b2b first result", result, 32'd15);
    n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b done drop", {31'd0, done}, 32'd0);
    wait_done(lat);
    chk("b2b second latency", 32'(lat), 32'd32);
    chk("b2b second result", result, 32'd2);
    go(32'd100, 32'd7, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      clk_en = !(lat + 1 >= 11 && lat + 1 <= 15);
      start = (lat + 1 == 4);
      dataa = 32'd9;
      datab = 32'd3;
      n = 1'b1;
    end while (!done && lat < 200);
    start = 1'b0;
    chk("stall latency", 32'(lat), 32'd37);
    chk("stall result", result, 32'd14);
    clk_en = 1'b0;
    @(negedge clk);
    chk("stall done hold", {31'd0, done}, 32'd1);
    clk_en = 1'b1;
    @(negedge clk);
    chk("stall done drop", {31'd0, done}, 32'd0);
    go(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    clk_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clk_en = 1'b1;
    start = 1'b0;
    chk("mid reset result", result, 32'd0);
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || result !== 32'd0) ok = 1'b0;
    end
    chk("post reset quiet", {31'd0, ok}, 32'd1);
    go(32'd1000, 32'd3, 1'b0);
    wait_done(lat);
    chk("after reset latency", 32'(lat), 32'd32);
    chk("after reset result", result, 32'd333);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
